alu_issue: RTL and testbench

Single-entry issue stage directly upstream of the RV32I `ALU`. It decodes one instruction per handshake into `aluSel`, `op1` and `op2`, and resolves register operands. Forwarding from the writeback port overrides register-file read data. Results are held in an output register with a valid/ready handshake, and the register outputs drive the `ALU` inputs directly.

---
 rtl/alu_issue_pkg.sv | 62 ++++++
 rtl/alu_issue_decode.sv | 100 ++++++++++
 rtl/alu_issue.sv | 112 +++++++++++
 tb/tb_alu_issue.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared RV32I definitions for the ALU issue stage: ALU operation select,
// opcode/funct7 constants and the operand forwarding helper.
package alu_issue_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_COPY1 = 4'd10
  } alu_sel_e;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // x0 is hardwired to zero, so a writeback to x0 is never forwarded.
  function automatic logic [XLEN-1:0] resolve_operand(
    input logic [REGW-1:0] idx,
    input logic [XLEN-1:0] rf_data,
    input logic            wb_valid,
    input logic [REGW-1:0] wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    if (idx == '0) begin
      return '0;
    end else if (wb_valid && (wb_rd == idx)) begin
      return wb_data;
    end else begin
      return rf_data;
    end
  endfunction

  function automatic alu_sel_e f3_base_sel(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode into ALU select and operands; operands arrive
// already resolved (forwarded) from the issue stage.
module rv32i_alu_decode
  import alu_issue_pkg::*;
(
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output alu_sel_e        aluSel,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic            wr_en,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rd_idx;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;

  assign opcode = inst[6:0];
  assign rd_idx = inst[11:7];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_u  = {inst[31:12], 12'b0};
  assign shamt  = {27'b0, inst[24:20]};

  always_comb begin
    aluSel  = ALU_ADD;
    op1     = '0;
    op2     = '0;
    wr_en   = 1'b0;
    illegal = 1'b0;

    case (opcode)
      OP: begin
        op1   = rs1_val;
        op2   = rs2_val;
        wr_en = 1'b1;
        if (f7 == F7_BASE) begin
          aluSel = f3_base_sel(f3);
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          aluSel = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          aluSel = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_IMM: begin
        op1   = rs1_val;
        op2   = imm_i;
        wr_en = 1'b1;
        if (f3 == 3'b001) begin
          op2 = shamt;
          if (f7 == F7_BASE) aluSel = ALU_SLL;
          else               illegal = 1'b1;
        end else if (f3 == 3'b101) begin
          op2 = shamt;
          if (f7 == F7_BASE)     aluSel = ALU_SRL;
          else if (f7 == F7_ALT) aluSel = ALU_SRA;
          else                   illegal = 1'b1;
        end else begin
          aluSel = f3_base_sel(f3);
        end
      end
      LUI: begin
        aluSel = ALU_COPY1;
        op1    = imm_u;
        wr_en  = 1'b1;
      end
      AUIPC: begin
        op1   = pc;
        op2   = imm_u;
        wr_en = 1'b1;
      end
      JAL, JALR: begin
        // ALU produces the link address pc+4
        op1   = pc;
        op2   = 32'd4;
        wr_en = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      aluSel = ALU_COPY1;
      op1    = '0;
      op2    = '0;
      wr_en  = 1'b0;
    end
    if (rd_idx == '0) wr_en = 1'b0;
  end

endmodule

// File: rtl/alu_issue.sv
// Single-entry issue stage feeding the RV32I ALU: writeback forwarding,
// decode, and a valid/ready output register.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_valid,
  input  logic [REGW-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output alu_sel_e        aluSel,
  output logic [REGW-1:0] rd,
  output logic            wr_en,
  output logic            illegal
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [XLEN-1:0] op2_q, op2_d;
  alu_sel_e        sel_q, sel_d;
  logic [REGW-1:0] rd_q, rd_d;
  logic            wr_q, wr_d;
  logic            ill_q, ill_d;

  logic            accept;
  logic [XLEN-1:0] rs1_res;
  logic [XLEN-1:0] rs2_res;
  alu_sel_e        dec_sel;
  logic [XLEN-1:0] dec_op1;
  logic [XLEN-1:0] dec_op2;
  logic            dec_wr;
  logic            dec_ill;

  // rst keeps in_ready high even while a held entry is being discarded.
  assign in_ready = rst || !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  assign rs1_res = resolve_operand(inst[19:15], rs1_data, wb_valid, wb_rd, wb_data);
  assign rs2_res = resolve_operand(inst[24:20], rs2_data, wb_valid, wb_rd, wb_data);

  rv32i_alu_decode u_decode (
    .inst    (inst),
    .pc      (pc),
    .rs1_val (rs1_res),
    .rs2_val (rs2_res),
    .aluSel  (dec_sel),
    .op1     (dec_op1),
    .op2     (dec_op2),
    .wr_en   (dec_wr),
    .illegal (dec_ill)
  );

  always_comb begin
    valid_d = valid_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    sel_d   = sel_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ill_d   = ill_q;
    if (accept) begin
      valid_d = 1'b1;
      op1_d   = dec_op1;
      op2_d   = dec_op2;
      sel_d   = dec_sel;
      rd_d    = inst[11:7];
      wr_d    = dec_wr;
      ill_d   = dec_ill;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      sel_q   <= ALU_ADD;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sel_q   <= sel_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid = valid_q;
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign aluSel    = sel_q;
  assign rd        = rd_q;
  assign wr_en     = wr_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: hand-encoded instructions with expected
// operands/selects, backpressure hold, same-cycle reload and reset while full.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  alu_sel_e    aluSel;
  logic [4:0]  rd;
  logic        wr_en;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst      (inst),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op1       (op1),
    .op2       (op2),
    .aluSel    (aluSel),
    .rd        (rd),
    .wr_en     (wr_en),
    .illegal   (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_op1, input logic [31:0] e_op2,
                         input logic [3:0] e_sel, input logic [4:0] e_rd,
                         input logic e_wr, input logic e_ill);
    chk({tag, ".valid"},   {31'b0, out_valid}, 32'd1);
    chk({tag, ".op1"},     op1, e_op1);
    chk({tag, ".op2"},     op2, e_op2);
    chk({tag, ".sel"},     {28'b0, aluSel}, {28'b0, e_sel});
    chk({tag, ".rd"},      {27'b0, rd}, {27'b0, e_rd});
    chk({tag, ".wr_en"},   {31'b0, wr_en}, {31'b0, e_wr});
    chk({tag, ".illegal"}, {31'b0, illegal}, {31'b0, e_ill});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; inst = 32'h00500093; pc = 32'h0;
    rs1_data = 32'h0; rs2_data = 32'h0; wb_valid = 1'b0; wb_rd = 5'd0;
    wb_data = 32'h0; out_ready = 1'b1;
    #1;
    chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
    step();
    step();
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.op1", op1, 32'd0);
    chk("rst.op2", op2, 32'd0);
    chk("rst.sel", {28'b0, aluSel}, 32'd0);
    chk("rst.rd", {27'b0, rd}, 32'd0);
    chk("rst.wr_illegal", {30'b0, wr_en, illegal}, 32'd0);

    // ADDI x1,x0,5
    rst = 1'b0; inst = 32'h00500093; rs1_data = 32'h1111_1111;
    step();
    chk_out("addi", 32'd0, 32'd5, 4'd0, 5'd1, 1'b1, 1'b0);

    // SUB x3,x1,x2 with x1 forwarded from writeback
    inst = 32'h402081B3; rs1_data = 32'd10; rs2_data = 32'd3;
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEADBEEF;
    step();
    chk_out("sub_fwd", 32'hDEADBEEF, 32'd3, 4'd1, 5'd3, 1'b1, 1'b0);

    // SRAI x5,x6,3
    inst = 32'h40335293; rs1_data = 32'h8000_0000; wb_valid = 1'b0;
    step();
    chk_out("srai", 32'h8000_0000, 32'd3, 4'd7, 5'd5, 1'b1, 1'b0);

    // LUI x7,0x12345
    inst = 32'h123453B7;
    step();
    chk_out("lui", 32'h12345000, 32'd0, 4'd10, 5'd7, 1'b1, 1'b0);

    // load opcode: illegal
    inst = 32'h00000003;
    step();
    chk_out("load_ill", 32'd0, 32'd0, 4'd10, 5'd0, 1'b0, 1'b1);

    // ADD x4,x0,x0 with a writeback to x0: no forward
    inst = 32'h00000233; wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h55;
    rs1_data = 32'h77; rs2_data = 32'h66;
    step();
    chk_out("add_x0", 32'd0, 32'd0, 4'd0, 5'd4, 1'b1, 1'b0);

    // ADDI x0,x1,1: rd=0 kills wr_en
    inst = 32'h00108013; wb_valid = 1'b0; rs1_data = 32'd7;
    step();
    chk_out("addi_rd0", 32'd7, 32'd1, 4'd0, 5'd0, 1'b0, 1'b0);

    // AUIPC x8,0x1 at pc 0x100
    inst = 32'h00001417; pc = 32'h100;
    step();
    chk_out("auipc", 32'h100, 32'h1000, 4'd0, 5'd8, 1'b1, 1'b0);

    // JAL x1 at pc 0x200
    inst = 32'h000000EF; pc = 32'h200;
    step();
    chk_out("jal", 32'h200, 32'd4, 4'd0, 5'd1, 1'b1, 1'b0);

    // MUL x1,x0,x0 (f7=0000001): illegal under OP
    inst = 32'h020000B3;
    step();
    chk_out("op_f7_ill", 32'd0, 32'd0, 4'd10, 5'd1, 1'b0, 1'b1);

    // backpressure: accept ADDI then stall three cycles with changing inputs
    inst = 32'h00500093;
    step();
    chk_out("bp_accept", 32'd0, 32'd5, 4'd0, 5'd1, 1'b1, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inst = 32'h123453B7 + i; wb_valid = 1'b1; wb_rd = 5'd1 + i[4:0];
      wb_data = 32'hCAFE0000 + i;
      #1;
      chk("bp.in_ready", {31'b0, in_ready}, 32'd0);
      step();
      chk_out("bp_hold", 32'd0, 32'd5, 4'd0, 5'd1, 1'b1, 1'b0);
    end

    // release with a new instruction: same-cycle consume and reload
    inst = 32'h123453B7; wb_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("reload.in_ready", {31'b0, in_ready}, 32'd1);
    step();
    chk_out("reload", 32'h12345000, 32'd0, 4'd10, 5'd7, 1'b1, 1'b0);

    // drain, then out_ready low while empty is harmless
    in_valid = 1'b0;
    step();
    chk("drain.valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    #1;
    chk("empty.in_ready", {31'b0, in_ready}, 32'd1);

    // reset while full
    in_valid = 1'b1; inst = 32'h40335293; rs1_data = 32'h8000_0000;
    step();
    chk("pre_rst.valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    step();
    chk("rst_full.valid", {31'b0, out_valid}, 32'd0);
    chk("rst_full.op1", op1, 32'd0);
    chk("rst_full.op2", op2, 32'd0);
    chk("rst_full.sel", {28'b0, aluSel}, 32'd0);
    chk("rst_full.rd", {27'b0, rd}, 32'd0);
    chk("rst_full.wr_illegal", {30'b0, wr_en, illegal}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
